// File: rtl/game_pkg.sv
// Shared types and constants for the motion mini-game blocks.
// Includes the difficulty helper used by the round scheduler.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        ISSUE
    } sched_state_t;

    localparam logic [1:0] REG_LT = 2'd0;
    localparam logic [1:0] REG_RT = 2'd1;
    localparam logic [1:0] REG_LB = 2'd2;
    localparam logic [1:0] REG_RB = 2'd3;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int         MAX_RETRY = 3;

    // max(base - idx*step, floor) at 9-bit signed width, so late rounds
    // saturate on the floor instead of wrapping through zero.
    function automatic logic [7:0] difficulty(input int base, input int step,
                                              input int floor_val,
                                              input logic [2:0] idx);
        logic signed [8:0] raw;
        raw = 9'(base - step * int'(idx));
        if (raw < $signed(9'(floor_val)))
            return 8'(floor_val);
        return raw[7:0];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with step enable, synchronous load and zero-lock recovery.
// next_value is the value the register takes on the next step.
module lfsr8 import game_pkg::*; #(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = LFSR_TAPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] next_value
);

    logic [7:0] value;

    // An all-zero register can never leave zero, so the next step reloads the seed.
    assign next_value = (value == 8'd0) ? SEED : {value[6:0], ^(value & TAPS)};

    always_ff @(posedge clk) begin
        if (reset)
            value <= SEED;
        else if (load)
            value <= load_value;
        else if (step || value == 8'd0)
            value <= next_value;
    end

endmodule

// File: rtl/round_scheduler.sv
// Per-session round scheduler: draws a non-repeating target region and issues
// one difficulty-scaled round descriptor per round over valid/ready.
module round_scheduler import game_pkg::*; #(
    parameter int         NUM_ROUNDS = 5,
    parameter int         HOLD_BASE  = 45,
    parameter int         HOLD_STEP  = 5,
    parameter int         HOLD_MIN   = 20,
    parameter int         PLAY_BASE  = 120,
    parameter int         PLAY_STEP  = 10,
    parameter int         PLAY_MIN   = 60,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       session_start,
    input  logic       session_abort,
    input  logic       round_ready,
    output logic       round_valid,
    output logic [1:0] region,
    output logic [7:0] hold_frames,
    output logic [7:0] play_limit,
    output logic [2:0] round_idx,
    output logic       busy,
    output logic       session_done
);

    sched_state_t state;
    logic [7:0]   lfsr_next;
    logic         last_valid;
    logic [1:0]   last_region;
    logic [1:0]   retry_cnt;
    logic [1:0]   draw_region;
    logic         draw_done;
    logic [7:0]   hold_next;
    logic [7:0]   play_next;

    lfsr8 #(
        .SEED(LFSR_SEED),
        .TAPS(LFSR_TAPS)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .step      (state == DRAW),
        .load      (1'b0),
        .load_value(LFSR_SEED),
        .next_value(lfsr_next)
    );

    assign hold_next = difficulty(HOLD_BASE, HOLD_STEP, HOLD_MIN, round_idx);
    assign play_next = difficulty(PLAY_BASE, PLAY_STEP, PLAY_MIN, round_idx);
    assign busy      = (state != IDLE);

    // A repeat of the previous region is rejected; the last allowed reject
    // forces the neighbouring region so a round is never delayed indefinitely.
    always_comb begin
        draw_region = lfsr_next[1:0];
        draw_done   = 1'b1;
        if (last_valid && lfsr_next[1:0] == last_region) begin
            draw_region = last_region + 2'd1;
            draw_done   = (retry_cnt == 2'(MAX_RETRY - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            round_valid  <= 1'b0;
            region       <= REG_LT;
            hold_frames  <= 8'd0;
            play_limit   <= 8'd0;
            round_idx    <= 3'd0;
            session_done <= 1'b0;
            last_valid   <= 1'b0;
            last_region  <= REG_LT;
            retry_cnt    <= 2'd0;
        end else begin
            session_done <= 1'b0;
            if (session_abort) begin
                state       <= IDLE;
                round_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        round_idx  <= 3'd0;
                        last_valid <= 1'b0;
                        retry_cnt  <= 2'd0;
                        if (session_start)
                            state <= DRAW;
                    end
                    DRAW: begin
                        if (draw_done) begin
                            region      <= draw_region;
                            hold_frames <= hold_next;
                            play_limit  <= play_next;
                            round_valid <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            retry_cnt <= retry_cnt + 2'd1;
                        end
                    end
                    ISSUE: begin
                        if (round_ready) begin
                            round_valid <= 1'b0;
                            last_region <= region;
                            last_valid  <= 1'b1;
                            retry_cnt   <= 2'd0;
                            if (round_idx == 3'(NUM_ROUNDS - 1)) begin
                                session_done <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                round_idx <= round_idx + 3'd1;
                                state     <= DRAW;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
